// File: rtl/pll_seq_pkg.sv
// ============================================================================
// Module   : pll_seq_pkg
// Brief    : Shared state encoding and sizing helpers for the PLL chain sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_ALL = 3'd0,
        RELEASE   = 3'd1,
        WAIT_LOCK = 3'd2,
        SETTLE    = 3'd3,
        READY     = 3'd4,
        FAULT     = 3'd5
    } seq_state_e;

    localparam int LOSS_CNT_MAX = 255;

    // Width of a counter that runs 0..limit-1; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_sync.sv
// ============================================================================
// Module   : pll_lock_sync
// Brief    : Two-flop synchroniser for a bus of independent async lock flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_chain_sequencer.sv
// ============================================================================
// Module   : pll_chain_sequencer
// Brief    : Releases a cascaded PLL chain stage by stage, gates the system reset
//            on full-chain lock, and supervises lock with retry and fault capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_chain_sequencer #(
    parameter int N_STAGES      = 7,
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                restart,
    input  logic [N_STAGES-1:0] pll_locked,
    output logic [N_STAGES-1:0] pll_rst,
    output logic                sys_reset_n,
    output logic                chain_ready,
    output logic                fault,
    output logic [3:0]          fault_stage,
    output logic [1:0]          retry_cnt,
    output logic [7:0]          loss_cnt
);

    import pll_seq_pkg::*;

    localparam int RW = cnt_width(RST_PULSE);
    localparam int TW = cnt_width(LOCK_TIMEOUT);
    localparam int SW = cnt_width(SETTLE_CYCLES);

    seq_state_e          state_q, state_d;
    logic [3:0]          stage_q, stage_d;
    logic [RW-1:0]       rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [1:0]          retry_q, retry_d;
    logic                fault_q, fault_d;
    logic [3:0]          fault_stage_q, fault_stage_d;
    logic [7:0]          loss_q, loss_d;
    logic [N_STAGES-1:0] pll_rst_q, pll_rst_d;
    logic                sys_reset_n_q, sys_reset_n_d;
    logic                chain_ready_q, chain_ready_d;

    logic [N_STAGES-1:0] lock_sync;
    logic [N_STAGES-1:0] stage_onehot;
    logic [N_STAGES-1:0] settled_mask;
    logic                cur_locked;
    logic                settled_lost;
    logic                timed_out;

    pll_lock_sync #(
        .WIDTH (N_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .rst_n   (reset_n),
        .async_i (pll_locked),
        .sync_o  (lock_sync)
    );

    // Stages below the current one have already settled; any of them dropping
    // invalidates the downstream clocks, so the whole chain restarts.
    assign stage_onehot = N_STAGES'(1) << stage_q;
    assign settled_mask = stage_onehot - N_STAGES'(1);
    assign cur_locked   = |(lock_sync & stage_onehot);
    assign settled_lost = |(~lock_sync & settled_mask);
    assign timed_out    = (timer_q == TW'(LOCK_TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        rst_cnt_d     = '0;
        timer_d       = timer_q;
        settle_d      = settle_q;
        retry_d       = retry_q;
        fault_d       = fault_q;
        fault_stage_d = fault_stage_q;
        loss_d        = loss_q;

        if (restart) begin
            state_d       = RESET_ALL;
            stage_d       = '0;
            retry_d       = '0;
            fault_d       = 1'b0;
            fault_stage_d = '0;
        end else begin
            unique case (state_q)
                RESET_ALL: begin
                    if (rst_cnt_q == RW'(RST_PULSE - 1)) begin
                        state_d = RELEASE;
                        stage_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                RELEASE: begin
                    timer_d = '0;
                    state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (settled_lost) begin
                        state_d = RESET_ALL;
                    end else if (timed_out) begin
                        if (retry_q < 2'(MAX_RETRY)) begin
                            retry_d = retry_q + 2'd1;
                            state_d = RESET_ALL;
                        end else begin
                            state_d       = FAULT;
                            fault_d       = 1'b1;
                            fault_stage_d = stage_q;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                        if (cur_locked) begin
                            state_d  = SETTLE;
                            settle_d = '0;
                        end
                    end
                end
                SETTLE: begin
                    // Lock timer is frozen here and resumes on a drop back to
                    // WAIT_LOCK, so glitches eat into the same per-stage budget.
                    if (settled_lost) begin
                        state_d = RESET_ALL;
                    end else if (!cur_locked) begin
                        state_d = WAIT_LOCK;
                    end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        if (stage_q == 4'(N_STAGES - 1)) begin
                            state_d = READY;
                            retry_d = '0;
                        end else begin
                            stage_d = stage_q + 4'd1;
                            state_d = RELEASE;
                        end
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                READY: begin
                    if (!(&lock_sync)) begin
                        state_d = RESET_ALL;
                        if (loss_q != 8'(LOSS_CNT_MAX)) begin
                            loss_d = loss_q + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = RESET_ALL;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        pll_rst_d = pll_rst_q;
        if ((state_d == RESET_ALL) || (state_d == FAULT)) begin
            pll_rst_d = '1;
        end else if (state_d == RELEASE) begin
            pll_rst_d = pll_rst_q & ~(N_STAGES'(1) << stage_d);
        end
        chain_ready_d = (state_d == READY);
        sys_reset_n_d = (state_d == READY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RESET_ALL;
            stage_q       <= '0;
            rst_cnt_q     <= '0;
            timer_q       <= '0;
            settle_q      <= '0;
            retry_q       <= '0;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
            loss_q        <= '0;
            pll_rst_q     <= '1;
            sys_reset_n_q <= 1'b0;
            chain_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            rst_cnt_q     <= rst_cnt_d;
            timer_q       <= timer_d;
            settle_q      <= settle_d;
            retry_q       <= retry_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
            loss_q        <= loss_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            chain_ready_q <= chain_ready_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sys_reset_n_q;
    assign chain_ready = chain_ready_q;
    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;
    assign retry_cnt   = retry_q;
    assign loss_cnt    = loss_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_chain_sequencer.sv
// ============================================================================
// Module   : tb_pll_chain_sequencer
// Brief    : Bench for pll_chain_sequencer: PLL lock emulator, cycle reference
//            model, directed table, hand sequences and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_chain_sequencer;

    localparam int N    = 7;
    localparam int RSTP = 4;
    localparam int LT   = 32;
    localparam int SC   = 8;
    localparam int MR   = 2;

    logic         clk;
    logic         reset_n;
    logic         restart;
    logic [N-1:0] pll_locked;
    logic [N-1:0] pll_rst;
    logic         sys_reset_n;
    logic         chain_ready;
    logic         fault;
    logic [3:0]   fault_stage;
    logic [1:0]   retry_cnt;
    logic [7:0]   loss_cnt;

    pll_chain_sequencer #(
        .N_STAGES      (N),
        .RST_PULSE     (RSTP),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SC),
        .MAX_RETRY     (MR)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .restart     (restart),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .chain_ready (chain_ready),
        .fault       (fault),
        .fault_stage (fault_stage),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- PLL emulator: lock follows its own reset release ------
    int           dly [N];
    int           cnt [N];
    logic [N-1:0] never_m;
    logic [N-1:0] force_m;

    task automatic drive_locks();
        for (int i = 0; i < N; i++)
            pll_locked[i] = !pll_rst[i] && (cnt[i] >= dly[i]) && !never_m[i] && !force_m[i];
    endtask

    task automatic env_update();
        for (int i = 0; i < N; i++) begin
            if (pll_rst[i]) cnt[i] = 0;
            else if (cnt[i] < 1000) cnt[i]++;
        end
        drive_locks();
    endtask

    // ---------------- reference model ---------------------------------------
    localparam int P_HOLD = 0, P_REL = 1, P_WAIT = 2, P_SET = 3, P_RDY = 4, P_FLT = 5;
    int ph, hold_n, stg, wait_n, set_n, retries, flt, fstg, losses, released;
    logic [N-1:0] h1, h2;

    task automatic model_reset();
        ph = P_HOLD; hold_n = 0; stg = 0; wait_n = 0; set_n = 0;
        retries = 0; flt = 0; fstg = 0; losses = 0; released = 0;
        h1 = '0; h2 = '0;
    endtask

    task automatic to_hold();
        ph = P_HOLD; hold_n = 0; released = 0;
    endtask

    task automatic model_edge(input logic r, input logic [N-1:0] raw);
        logic [N-1:0] ls;
        logic         lost_low;
        logic         cur;
        ls = h2; h2 = h1; h1 = raw;
        lost_low = 1'b0;
        for (int i = 0; i < N; i++) if (i < stg && !ls[i]) lost_low = 1'b1;
        cur = ls[stg];
        if (r) begin
            to_hold(); retries = 0; flt = 0; fstg = 0;
        end else begin
            case (ph)
                P_HOLD: if (hold_n == RSTP - 1) begin ph = P_REL; stg = 0; released = 1; end
                        else hold_n++;
                P_REL:  begin wait_n = 0; ph = P_WAIT; end
                P_WAIT: begin
                    if (lost_low) to_hold();
                    else if (wait_n == LT - 1) begin
                        if (retries < MR) begin retries++; to_hold(); end
                        else begin ph = P_FLT; flt = 1; fstg = stg; released = 0; end
                    end else begin
                        wait_n++;
                        if (cur) begin ph = P_SET; set_n = 0; end
                    end
                end
                P_SET: begin
                    if (lost_low) to_hold();
                    else if (!cur) ph = P_WAIT;
                    else if (set_n == SC - 1) begin
                        if (stg == N - 1) begin ph = P_RDY; retries = 0; end
                        else begin stg++; released = stg + 1; ph = P_REL; end
                    end else set_n++;
                end
                P_RDY: if (ls != '1) begin
                    if (losses < 255) losses++;
                    to_hold();
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [N-1:0] m;
        logic         rdy;
        m   = N'((1 << released) - 1);
        rdy = (ph == P_RDY);
        return {8'd0, ~m, rdy, rdy, flt[0], fstg[3:0], retries[1:0], losses[7:0]};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {8'd0, pll_rst, sys_reset_n, chain_ready, fault, fault_stage, retry_cnt, loss_cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (!reset_n) model_reset();
        else model_edge(restart, pll_locked);
        check("cycle", dut_vec(), model_vec());
        env_update();
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_pll_rst"},     32'(pll_rst), 32'h7F);
        check({p, "_sys_reset_n"}, 32'(sys_reset_n), 0);
        check({p, "_chain_ready"}, 32'(chain_ready), 0);
        check({p, "_fault"},       32'(fault), 0);
        check({p, "_fault_stage"}, 32'(fault_stage), 0);
        check({p, "_retry_cnt"},   32'(retry_cnt), 0);
        check({p, "_loss_cnt"},    32'(loss_cnt), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; restart = 1'b0;
        force_m = '0; never_m = '0; pll_locked = '0;
        for (int i = 0; i < N; i++) begin dly[i] = 5; cnt[i] = 0; end
        model_reset();
        step(); step();
        reset_n = 1'b1;
    endtask

    // ---------------- directed table ----------------------------------------
    typedef struct {
        int           never_stage;
        int           glitch_stage;
        logic         exp_ready;
        logic         exp_fault;
        logic [3:0]   exp_fs;
        logic [1:0]   exp_retry;
        logic [N-1:0] exp_rst;
    } vec_t;

    vec_t tbl [5];
    int   n, r;
    logic glitched;

    initial begin
        tbl[0] = '{-1, -1, 1'b1, 1'b0, 4'd0, 2'd0, 7'h00};
        tbl[1] = '{ 3, -1, 1'b0, 1'b1, 4'd3, 2'd2, 7'h7F};
        tbl[2] = '{-1,  2, 1'b1, 1'b0, 4'd0, 2'd0, 7'h00};
        tbl[3] = '{ 0, -1, 1'b0, 1'b1, 4'd0, 2'd2, 7'h7F};
        tbl[4] = '{ 6, -1, 1'b0, 1'b1, 4'd6, 2'd2, 7'h7F};

        do_reset();
        check_reset_vals("por");

        for (int t = 0; t < 5; t++) begin
            do_reset();
            if (tbl[t].never_stage >= 0) never_m[tbl[t].never_stage] = 1'b1;
            glitched = (tbl[t].glitch_stage < 0);
            n = 0;
            while (!(chain_ready || fault) && n < 2000) begin
                if (!glitched && ph == P_SET && stg == tbl[t].glitch_stage && set_n == 3) begin
                    force_m[tbl[t].glitch_stage] = 1'b1; drive_locks();
                    step();
                    force_m = '0; drive_locks();
                    glitched = 1'b1;
                end else begin
                    step();
                end
                n++;
            end
            check($sformatf("tbl%0d_bounded", t), 32'(n < 2000), 1);
            check($sformatf("tbl%0d_ready", t),   32'(chain_ready), 32'(tbl[t].exp_ready));
            check($sformatf("tbl%0d_sysrst", t),  32'(sys_reset_n), 32'(tbl[t].exp_ready));
            check($sformatf("tbl%0d_fault", t),   32'(fault), 32'(tbl[t].exp_fault));
            check($sformatf("tbl%0d_fstage", t),  32'(fault_stage), 32'(tbl[t].exp_fs));
            check($sformatf("tbl%0d_retry", t),   32'(retry_cnt), 32'(tbl[t].exp_retry));
            check($sformatf("tbl%0d_pll_rst", t), 32'(pll_rst), 32'(tbl[t].exp_rst));
        end

        // Lock loss on stage 5 while READY.
        do_reset();
        n = 0;
        while (!chain_ready && n < 500) begin step(); n++; end
        check("drop_bringup", 32'(chain_ready), 1);
        force_m[5] = 1'b1; drive_locks();
        n = 0;
        while (chain_ready && n < 10) begin step(); n++; end
        check("drop_latency_le3", 32'(n <= 3), 1);
        check("drop_sys_reset_n", 32'(sys_reset_n), 0);
        check("drop_loss_cnt", 32'(loss_cnt), 1);
        force_m = '0;
        r = 0;
        while (pll_rst == 7'h7F && r < 20) begin r++; step(); end
        check("drop_rst_hold", 32'(r), 4);
        n = 0;
        while (!chain_ready && n < 500) begin step(); n++; end
        check("drop_reready", 32'(chain_ready), 1);
        check("drop_loss_kept", 32'(loss_cnt), 1);

        // Async reset in the middle of stage 4 settling.
        restart = 1'b1; step(); restart = 1'b0;
        n = 0;
        while (!(ph == P_SET && stg == 4 && set_n == 2) && n < 500) begin step(); n++; end
        check("arst_reach_settle4", 32'(n < 500), 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("arst");
        model_reset();
        step(); step();
        reset_n = 1'b1;
        n = 0;
        while (!chain_ready && n < 500) begin step(); n++; end
        check("arst_reready", 32'(chain_ready), 1);

        // Restart out of FAULT, then restart colliding with the final timeout.
        do_reset();
        never_m[3] = 1'b1;
        n = 0;
        while (!fault && n < 2000) begin step(); n++; end
        check("flt_reached", 32'(fault), 1);
        restart = 1'b1; step(); restart = 1'b0;
        check("flt_restart_fault", 32'(fault), 0);
        check("flt_restart_retry", 32'(retry_cnt), 0);
        check("flt_restart_pll_rst", 32'(pll_rst), 32'h7F);
        n = 0;
        while (!(ph == P_WAIT && retries == MR && wait_n == LT - 1) && n < 2000) begin step(); n++; end
        check("coll_reached", 32'(n < 2000), 1);
        restart = 1'b1; step(); restart = 1'b0;
        check("coll_fault", 32'(fault), 0);
        check("coll_retry", 32'(retry_cnt), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 1000 == 0) begin
                never_m = '0;
                for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 12));
                if ($urandom_range(0, 3) == 0) never_m[$urandom_range(0, N - 1)] = 1'b1;
            end
            restart = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 79) == 0) force_m[$urandom_range(0, N - 1)] = 1'b1;
            else if ($urandom_range(0, 3) == 0) force_m = '0;
            drive_locks();
            step();
        end
        restart = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pll_chain_sequencer.md
Name: pll_chain_sequencer

Overview:
Sequences bring-up of the cascaded PLL chain that feeds the OFDM datapath clock.
- Holds every PLL stage in reset, then releases stages one at a time, upstream first.
- Waits for each stage's lock, and requires that lock to stay stable, before releasing the next stage.
- Releases the system reset only when the whole chain is locked.
- Monitors lock during operation, retries on timeout and latches a fault with the failing stage.

Parameters:
N_STAGES, 7, number of cascaded PLL stages (1..16)
RST_PULSE, 16, cycles all PLL resets are held before sequencing starts
LOCK_TIMEOUT, 65535, cycles allowed per stage for lock before a retry
SETTLE_CYCLES, 256, consecutive locked cycles required per stage
MAX_RETRY, 3, timeout retries allowed before FAULT

Ports:
clk  in  1  free-running reference clock (board oscillator, not a PLL output)
reset_n  in  1  asynchronous active-low reset
restart  in  1  synchronous pulse; forces a full re-sequence and clears fault/retry
pll_locked  in  N_STAGES  raw lock indicators, asynchronous to clk; bit i = stage i
pll_rst  out  N_STAGES  active-high PLL resets; bit i = stage i
sys_reset_n  out  1  active-low system reset for datapath logic
chain_ready  out  1  high while all stages are locked and settled
fault  out  1  sticky fault flag
fault_stage  out  4  stage index that timed out on the final retry
retry_cnt  out  2  timeout retries used in the current sequence
loss_cnt  out  8  saturating count of lock losses seen in READY

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous, active-low, on `reset_n`. All state is async-cleared.
- Values on reset:
  - pll_rst = all ones; sys_reset_n = 0; chain_ready = 0
  - fault = 0; fault_stage = 0; retry_cnt = 0; loss_cnt = 0
  - FSM in RESET_ALL; stage index = 0; timers = 0
- pll_locked is synchronised by a 2-flop synchroniser per bit. All decisions use the synchronised value (2-cycle latency). All outputs are registered.
- RESET_ALL:
  - pll_rst = all ones; sys_reset_n = 0; chain_ready = 0.
  - Counts RST_PULSE cycles, then stage = 0 and goes to RELEASE.
- RELEASE (one cycle):
  - Clears pll_rst[stage]. Bits below stage are already clear; bits above stay set.
  - Clears the timer, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - Timer increments each cycle.
  - lock_sync[stage] = 1 → SETTLE, with the settle counter cleared.
  - Timer reaches LOCK_TIMEOUT-1 first:
    - retry_cnt < MAX_RETRY → retry_cnt++, go to RESET_ALL.
    - otherwise → FAULT, with fault_stage = stage.
- SETTLE:
  - Settle counter increments while lock_sync[stage] = 1.
  - Lock drops → back to WAIT_LOCK. The lock timer is not cleared, so the timeout budget is per stage.
  - Counter reaches SETTLE_CYCLES-1:
    - stage == N_STAGES-1 → READY.
    - otherwise stage++ and go to RELEASE.
  - Any already-settled stage i < stage losing lock during WAIT_LOCK or SETTLE → RESET_ALL. retry_cnt is unchanged.
- READY:
  - sys_reset_n = 1 and chain_ready = 1, both from the registered outputs, in the cycle after the READY transition.
  - retry_cnt is cleared on entry.
  - Any lock_sync bit = 0 → next cycle chain_ready = 0 and sys_reset_n = 0. loss_cnt increments (saturates at 255). Then go to RESET_ALL.
- FAULT:
  - pll_rst = all ones; sys_reset_n = 0; chain_ready = 0; fault = 1.
  - Stays in FAULT until restart.
- restart = 1 in any state → RESET_ALL next cycle, and retry_cnt = 0, fault = 0, fault_stage = 0. loss_cnt is not cleared.
- Priority (highest first): restart, lock loss, timeout, lock/settle progress.
- Timer widths are $clog2 of their limit; no wrap is possible because every counter is bounded by a state exit.
- fault_stage width 4 covers N_STAGES ≤ 16.

Decomposition:
- Package pll_seq_pkg:
  - state enum {RESET_ALL, RELEASE, WAIT_LOCK, SETTLE, READY, FAULT}
  - counter-width localparam functions
  - LOSS_CNT_MAX = 255
- Sub-module pll_lock_sync: parameterised-width 2-flop synchroniser, async active-low reset to 0, used for pll_locked.

Test Plan:
Bench parameters: N_STAGES=7, RST_PULSE=4, LOCK_TIMEOUT=32, SETTLE_CYCLES=8, MAX_RETRY=2.
- Clean bring-up: each stage's lock rises 5 cycles after its pll_rst bit clears → pll_rst clears bit 0 first, then one bit at a time up to 7'h00; chain_ready = 1 and sys_reset_n = 1 after the 7th settle; retry_cnt = 0.
- Stage 3 never locks → after 32 cycles in WAIT_LOCK, 2 retries (retry_cnt = 1, then 2), then fault = 1, fault_stage = 3, pll_rst = 7'h7F.
- Stage 2 lock glitches low for 1 cycle in mid-SETTLE → FSM returns to WAIT_LOCK, the settle count restarts, bring-up completes without a retry.
- Stage 5 lock drops in READY → chain_ready and sys_reset_n go to 0 within 3 cycles of the raw drop, loss_cnt = 1, pll_rst = 7'h7F for 4 cycles, then re-sequence.
- In FAULT, pulse restart → fault = 0 and retry_cnt = 0 next cycle, re-sequence starts; restart asserted in the same cycle as a timeout wins (no retry_cnt increment).
- Assert reset_n low mid-SETTLE of stage 4 → outputs immediately return to their reset values; loss_cnt = 0.
